// File: rtl/core_pkg.sv
// Shared core definitions: RV32I opcodes, branch FSM states, default latencies
// and source-operand decode helpers for the ID-stage hazard unit.
package core_pkg;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_S    = 7'b0100011;
    localparam logic [6:0] OP_SB   = 7'b1100011;
    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_IALU = 7'b0010011;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    localparam int WB_LAT_DEF = 3;
    localparam int BR_LAT_DEF = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BR_WAIT = 2'd1,
        BR_DONE = 2'd2
    } br_state_t;

    function automatic logic uses_rs1(input logic [6:0] op);
        case (op)
            OP_R, OP_S, OP_SB, OP_LOAD, OP_IALU, OP_JALR: uses_rs1 = 1'b1;
            default:                                      uses_rs1 = 1'b0;
        endcase
    endfunction

    function automatic logic uses_rs2(input logic [6:0] op);
        case (op)
            OP_R, OP_S, OP_SB: uses_rs2 = 1'b1;
            default:           uses_rs2 = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/scoreboard_entry.sv
// One architectural register's pending-write countdown (plus load tag when
// HAZARD_FORWARDING_EN is defined).
module scoreboard_entry #(
    parameter int WB_LAT = 3,
    parameter int CNT_W  = 3
) (
    input  logic clock,
    input  logic reset,
    input  logic i_load,
    input  logic i_is_load,
    output logic o_busy,
    output logic o_blocked
);

    logic [CNT_W-1:0] r_cnt;

    // Reload on issue takes priority over the saturating countdown
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (i_load) begin
            r_cnt <= CNT_W'(WB_LAT);
        end else if (r_cnt != {CNT_W{1'b0}}) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_busy = (r_cnt != {CNT_W{1'b0}});

`ifdef HAZARD_FORWARDING_EN
    logic r_is_load;

    // Track whether the outstanding write comes from a load
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_is_load <= 1'b0;
        end else if (i_load) begin
            r_is_load <= i_is_load;
        end else begin
            r_is_load <= r_is_load;
        end
    end

    // Only the load-use slot cannot be bypassed
    assign o_blocked = r_is_load & (r_cnt == CNT_W'(WB_LAT));
`else
    logic w_unused_is_load;
    assign w_unused_is_load = i_is_load;
    assign o_blocked        = o_busy;
`endif

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard unit: per-register countdown scoreboard and branch-resolution
// FSM. Define HAZARD_FORWARDING_EN to reduce stalls to load-use only.
module hazard_scoreboard
    import core_pkg::*;
#(
    parameter int NREG   = 32,
    parameter int REG_W  = 5,
    parameter int WB_LAT = WB_LAT_DEF,
    parameter int BR_LAT = BR_LAT_DEF,
    parameter int CNT_W  = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [6:0]       opcode,
    input  logic [REG_W-1:0] rs1,
    input  logic [REG_W-1:0] rs2,
    input  logic [REG_W-1:0] rd,
    input  logic             rd_we,
    input  logic             branch_taken,
    output logic             pc_load,
    output logic             if_id_load,
    output logic             id_ex_bubble,
    output logic             if_id_flush,
    output logic [NREG-1:0]  busy
);

    br_state_t        r_state;
    logic [CNT_W-1:0] r_br_cnt;
    logic             r_taken_q;

    logic [NREG-1:0]  w_blocked;
    logic [NREG-1:0]  w_busy;
    logic             w_data_hazard;
    logic             w_issue;
    logic             w_is_load_op;

    assign w_blocked[0] = 1'b0;
    assign w_busy[0]    = 1'b0;
    assign w_is_load_op = (opcode == OP_LOAD);

    for (genvar g = 1; g < NREG; g++) begin : g_entry
        logic w_load;
        assign w_load = w_issue & rd_we & (rd == REG_W'(g));
        scoreboard_entry #(
            .WB_LAT (WB_LAT),
            .CNT_W  (CNT_W)
        ) u_entry (
            .clock     (clock),
            .reset     (reset),
            .i_load    (w_load),
            .i_is_load (w_is_load_op),
            .o_busy    (w_busy[g]),
            .o_blocked (w_blocked[g])
        );
    end

    assign w_data_hazard = id_valid &
                           ((uses_rs1(opcode) & w_blocked[rs1]) |
                            (uses_rs2(opcode) & w_blocked[rs2]));
    assign w_issue = id_valid & ~w_data_hazard & (r_state == IDLE);
    assign busy    = w_busy;

    // Branch-resolution FSM: wait BR_LAT cycles, latch the outcome, then flush
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_br_cnt  <= {CNT_W{1'b0}};
            r_taken_q <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_issue && (opcode == OP_SB)) begin
                        r_state  <= BR_WAIT;
                        r_br_cnt <= CNT_W'(BR_LAT - 1);
                    end else begin
                        r_state <= IDLE;
                    end
                end
                BR_WAIT: begin
                    if (r_br_cnt == {CNT_W{1'b0}}) begin
                        r_taken_q <= branch_taken;
                        r_state   <= BR_DONE;
                    end else begin
                        r_br_cnt <= r_br_cnt - CNT_W'(1);
                    end
                end
                BR_DONE: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Pipeline control decode from FSM state and current hazard
    always_comb begin
        pc_load      = 1'b1;
        if_id_load   = 1'b1;
        id_ex_bubble = 1'b0;
        if_id_flush  = 1'b0;
        case (r_state)
            IDLE: begin
                pc_load      = ~w_data_hazard;
                if_id_load   = ~w_data_hazard;
                id_ex_bubble = w_data_hazard;
            end
            BR_WAIT: begin
                if (r_br_cnt == {CNT_W{1'b0}}) begin
                    pc_load = 1'b1;
                end else begin
                    pc_load = 1'b0;
                end
                if_id_load   = 1'b0;
                id_ex_bubble = 1'b1;
            end
            BR_DONE: begin
                id_ex_bubble = 1'b1;
                if_id_flush  = r_taken_q;
            end
            default: begin
                pc_load      = 1'b1;
                if_id_load   = 1'b1;
                id_ex_bubble = 1'b0;
                if_id_flush  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard (default parameters);
// stall expectations follow HAZARD_FORWARDING_EN when it is defined.
module tb_hazard_scoreboard;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_SB   = 7'b1100011;
    localparam logic [6:0] OP_LOAD = 7'b0000011;

`ifdef HAZARD_FORWARDING_EN
    localparam int ALU_STALL  = 0;
    localparam int LOAD_STALL = 1;
`else
    localparam int ALU_STALL  = 3;
    localparam int LOAD_STALL = 3;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        id_valid = 1'b0;
    logic [6:0]  opcode = 7'd0;
    logic [4:0]  rs1 = 5'd0;
    logic [4:0]  rs2 = 5'd0;
    logic [4:0]  rd = 5'd0;
    logic        rd_we = 1'b0;
    logic        branch_taken = 1'b0;
    logic        pc_load;
    logic        if_id_load;
    logic        id_ex_bubble;
    logic        if_id_flush;
    logic [31:0] busy;

    int n_tests = 0;
    int n_fail  = 0;

    hazard_scoreboard dut (
        .clock        (clock),
        .reset        (reset),
        .id_valid     (id_valid),
        .opcode       (opcode),
        .rs1          (rs1),
        .rs2          (rs2),
        .rd           (rd),
        .rd_we        (rd_we),
        .branch_taken (branch_taken),
        .pc_load      (pc_load),
        .if_id_load   (if_id_load),
        .id_ex_bubble (id_ex_bubble),
        .if_id_flush  (if_id_flush),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] exp);
        chk(tag, {28'd0, pc_load, if_id_load, id_ex_bubble, if_id_flush}, {28'd0, exp});
    endtask

    task automatic set_id(input logic v, input logic [6:0] op, input logic [4:0] a,
                          input logic [4:0] b, input logic [4:0] d, input logic we);
        id_valid = v; opcode = op; rs1 = a; rs2 = b; rd = d; rd_we = we;
        #2;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drain();
        set_id(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        for (int i = 0; i < 5; i++) tick();
    endtask

    initial begin
        #2;
        chk_out("reset_out", 4'b1100);
        chk("reset_busy", busy, 32'd0);
        tick();
        reset = 1'b1;
        tick();

        // add x5 then dependent add x6,x5,x1
        set_id(1'b1, OP_R, 5'd1, 5'd2, 5'd5, 1'b1);
        chk_out("raw_producer", 4'b1100);
        tick();
        set_id(1'b1, OP_R, 5'd5, 5'd1, 5'd6, 1'b1);
        chk("raw_busy5", {31'd0, busy[5]}, 32'd1);
        for (int i = 0; i < ALU_STALL; i++) begin
            chk_out("raw_stall", 4'b0010);
            tick();
            #2;
        end
        chk_out("raw_issue", 4'b1100);
        tick();
        drain();
        chk("drain_busy", busy, 32'd0);

        // lw x5 then dependent add
        set_id(1'b1, OP_LOAD, 5'd1, 5'd0, 5'd5, 1'b1);
        tick();
        set_id(1'b1, OP_R, 5'd5, 5'd2, 5'd6, 1'b1);
        for (int i = 0; i < LOAD_STALL; i++) begin
            chk_out("load_stall", 4'b0010);
            tick();
            #2;
        end
        chk_out("load_issue", 4'b1100);
        tick();
        drain();

        // beq x1,x2 taken, then not taken
        for (int t = 1; t >= 0; t--) begin
            set_id(1'b1, OP_SB, 5'd1, 5'd2, 5'd0, 1'b0);
            chk_out("br_issue", 4'b1100);
            tick();
            set_id(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
            chk_out("br_wait1", 4'b0010);
            tick();
            branch_taken = (t == 1);
            #2;
            chk_out("br_wait_last", 4'b1010);
            tick();
            branch_taken = 1'b0;
            #2;
            chk_out("br_done", {3'b111, (t == 1)});
            tick();
            #2;
            chk_out("br_idle", 4'b1100);
            tick();
        end

        // x0 is never tracked
        set_id(1'b1, OP_R, 5'd0, 5'd0, 5'd0, 1'b1);
        tick();
        set_id(1'b1, OP_R, 5'd0, 5'd0, 5'd3, 1'b1);
        chk_out("x0_read", 4'b1100);
        chk("x0_busy", busy, 32'd0);
        tick();
        drain();

        // WAW: second add x7 reloads the countdown
        set_id(1'b1, OP_R, 5'd1, 5'd2, 5'd7, 1'b1);
        tick();
        set_id(1'b1, OP_R, 5'd1, 5'd2, 5'd7, 1'b1);
        chk_out("waw_reissue", 4'b1100);
        tick();
        set_id(1'b1, OP_R, 5'd7, 5'd1, 5'd8, 1'b1);
        chk("waw_busy7", {31'd0, busy[7]}, 32'd1);
        for (int i = 0; i < ALU_STALL; i++) begin
            chk_out("waw_stall", 4'b0010);
            tick();
            #2;
        end
        chk_out("waw_issue", 4'b1100);
        tick();
        drain();

        // Reset asserted mid-BR_WAIT with a pending write
        set_id(1'b1, OP_R, 5'd1, 5'd2, 5'd9, 1'b1);
        tick();
        set_id(1'b1, OP_SB, 5'd1, 5'd2, 5'd0, 1'b0);
        tick();
        set_id(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        chk_out("pre_rst_wait", 4'b0010);
        chk("pre_rst_busy9", {31'd0, busy[9]}, 32'd1);
        reset = 1'b0;
        #1;
        chk_out("mid_rst_out", 4'b1100);
        chk("mid_rst_busy", busy, 32'd0);
        tick();
        reset = 1'b1;
        set_id(1'b1, OP_R, 5'd9, 5'd1, 5'd10, 1'b1);
        chk_out("post_rst_issue", 4'b1100);
        tick();
        #2;
        chk("post_rst_busy10", busy, 32'h0000_0400);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
